univ_reg_en: RTL and testbench
==============================

UNIV_REG_EN -- requirements
Module: univ_reg_en

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value loaded into q on reset.
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit, SHALL permit a state update when 1.
REQ-006 Port mode, input, 3 bits, SHALL select the operation (see REQ-012).
REQ-007 Port data, input, WIDTH bits, SHALL be the parallel load value.
REQ-008 Port serial_in, input, 1 bit, SHALL be the bit shifted in during shift modes.
REQ-009 Port q, output, WIDTH bits, SHALL be the registered state.
REQ-010 Port serial_out, output, 1 bit, SHALL be the combinational bit leaving q in shift and rotate modes.
REQ-011 Port wrap, output, 1 bit, SHALL be a registered one-cycle pulse flagging a counter wrap.

Function
REQ-012 On a rising clock edge with reset=0 and enable=1, q SHALL update per mode:
 - 000: hold.
 - 001: load, q<=data.
 - 010: shift left, q<={q[WIDTH-2:0],serial_in}.
 - 011: shift right, q<={serial_in,q[WIDTH-1:1]}.
 - 100: rotate left, q<={q[WIDTH-2:0],q[WIDTH-1]}.
 - 101: rotate right, q<={q[0],q[WIDTH-1:1]}.
 - 110: count up, q<=q+1 modulo 2^WIDTH.
 - 111: count down, q<=q-1 modulo 2^WIDTH.
REQ-013 With enable=0 and reset=0, q SHALL hold for any mode, data or serial_in, and wrap SHALL be 0 on the next cycle.
REQ-014 serial_out SHALL be q[WIDTH-1] for mode 010 or 100, q[0] for mode 011 or 101, and 0 otherwise; it SHALL be independent of enable.
REQ-015 wrap SHALL be 1 for exactly one cycle after an enabled edge in mode 110 with q at all ones, or in mode 111 with q at all zeros; otherwise it SHALL be 0 after each edge.
REQ-016 Each enabled edge SHALL be a single-cycle operation: q reflects it on the edge it is sampled, with latency 1.
REQ-017 Shift and rotate modes SHALL move exactly one bit position per enabled edge, and no bits other than those listed SHALL change.
REQ-018 Mode changes between consecutive edges SHALL take effect immediately, with no pipeline or residual state except q and wrap.
REQ-019 No input value combination SHALL produce X on q, serial_out or wrap once reset has been applied.

Reset
REQ-020 When reset=1 at a rising edge, q SHALL become RESET_VAL and wrap SHALL become 0, regardless of enable, mode, data and serial_in.
REQ-021 Reset SHALL take priority over every operation, including mid-count and mid-shift; the following enabled edge resumes from RESET_VAL.
REQ-022 Before the first reset edge, outputs SHALL be undefined; reset SHALL have no effect between edges.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-023 Load/enable: reset, then mode=001 data=8'hA5 enable=0 for 2 edges -> q=8'h00; set enable=1, 1 edge -> q=8'hA5; set data=8'h3C enable=0 -> q stays 8'hA5.
REQ-024 Shift: q=8'h81, mode=010 serial_in=0 -> q=8'h02 and serial_out was 1 before the edge; then mode=011 serial_in=1 -> q=8'h81.
REQ-025 Rotate: q=8'h01, mode=100 for 8 edges -> q returns to 8'h01; mode=101 for 1 edge from 8'h01 -> q=8'h80.
REQ-026 Counter wrap: load 8'hFE, mode=110 for 2 edges -> q=8'hFF then 8'h00, wrap=1 only after the second edge; mode=111 from 8'h00 -> q=8'hFF, wrap=1 for one cycle.
REQ-027 Reset priority: counting up at q=8'h7F with enable=1, assert reset for 1 edge -> q=8'h00, wrap=0; deassert -> the next edge gives q=8'h01. Repeat with RESET_VAL=8'h55 -> q=8'h55 after reset.
REQ-028 Randomised mode/enable/data stimulus for at least 10000 cycles SHALL match a reference model on q, serial_out and wrap every cycle.

Source files
------------

// File: rtl/univ_reg_en.sv
// Universal WIDTH-bit register: hold, parallel load, shift, rotate and up/down count,
// with a registered one-cycle wrap pulse when the counter rolls over.
module univ_reg_en #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             wrap
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_UP    = 3'b110;
    localparam logic [2:0] MODE_DOWN  = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (enable) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_LOAD: q_next = data;
                MODE_SHL:  q_next = {q[WIDTH-2:0], serial_in};
                MODE_SHR:  q_next = {serial_in, q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                MODE_UP: begin
                    q_next    = q + ONE;
                    wrap_next = (q == ALL_ONES);
                end
                MODE_DOWN: begin
                    q_next    = q - ONE;
                    wrap_next = (q == ZERO);
                end
                default: q_next = q;
            endcase
        end
    end

    // serial_out follows the mode only, so it is visible even while enable is low.
    always_comb begin
        serial_out = 1'b0;
        case (mode)
            MODE_SHL, MODE_ROL: serial_out = q[WIDTH-1];
            MODE_SHR, MODE_ROR: serial_out = q[0];
            default:            serial_out = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_univ_reg_en.sv
// Bench for univ_reg_en: two instances (RESET_VAL 0 and 8'h55) share stimulus; a driver
// pushes expectations into a queue and a monitor pops and compares after each edge.
module tb_univ_reg_en;

    localparam int W  = 8;
    localparam int EW = 2 * (W + 2) + 1;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] data = '0;
    logic         serial_in = 1'b0;

    logic [W-1:0] q0, q5;
    logic         so0, so5, wr0, wr5;

    always #5 clock = ~clock;

    univ_reg_en #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .data(data),
        .serial_in(serial_in), .q(q0), .serial_out(so0), .wrap(wr0)
    );

    univ_reg_en #(.WIDTH(W), .RESET_VAL(8'h55)) dut55 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .data(data),
        .serial_in(serial_in), .q(q5), .serial_out(so5), .wrap(wr5)
    );

    // Entry layout: {check_so, q0, wrap0, so0_pre, q55, wrap55, so55_pre}
    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            checks = 0;
    int            errors = 0;

    logic [W-1:0] m0, m5;

    function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic en,
                                                input logic [2:0] md, input logic [W-1:0] d,
                                                input logic sin);
        if (!en) return cur;
        case (md)
            3'b000:  return cur;
            3'b001:  return d;
            3'b010:  return {cur[W-2:0], sin};
            3'b011:  return {sin, cur[W-1:1]};
            3'b100:  return {cur[W-2:0], cur[W-1]};
            3'b101:  return {cur[0], cur[W-1:1]};
            3'b110:  return cur + 8'd1;
            default: return cur - 8'd1;
        endcase
    endfunction

    function automatic logic model_wrap(input logic [W-1:0] cur, input logic en, input logic [2:0] md);
        return en && ((md == 3'b110 && cur == 8'hFF) || (md == 3'b111 && cur == 8'h00));
    endfunction

    function automatic logic model_so(input logic [W-1:0] cur, input logic [2:0] md);
        if (md == 3'b010 || md == 3'b100) return cur[W-1];
        if (md == 3'b011 || md == 3'b101) return cur[0];
        return 1'b0;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%h required=%h", tag, fld, act, exp);
        end
    endtask

    // Driver: applies one cycle of inputs at the falling edge and queues what the
    // following rising edge must produce. hand=1 takes dut0 values from the caller.
    task automatic step(input logic rst, input logic en, input logic [2:0] md,
                        input logic [W-1:0] d, input logic sin, input logic hand,
                        input logic [W-1:0] hq, input logic hw, input logic hso,
                        input logic chk_so, input string tag);
        logic [W-1:0] n0, n5;
        logic w0, w5, s0, s5;
        @(negedge clock);
        reset = rst; enable = en; mode = md; data = d; serial_in = sin;
        s0 = model_so(m0, md);
        s5 = model_so(m5, md);
        n0 = rst ? 8'h00 : model_next(m0, en, md, d, sin);
        n5 = rst ? 8'h55 : model_next(m5, en, md, d, sin);
        w0 = rst ? 1'b0 : model_wrap(m0, en, md);
        w5 = rst ? 1'b0 : model_wrap(m5, en, md);
        if (hand) begin
            exp_q.push_back({chk_so, hq, hw, hso, n5, w5, s5});
        end else begin
            exp_q.push_back({chk_so, n0, w0, s0, n5, w5, s5});
        end
        tag_q.push_back(tag);
        m0 = n0;
        m5 = n5;
    endtask

    task automatic h(input logic rst, input logic en, input logic [2:0] md, input logic [W-1:0] d,
                     input logic sin, input logic [W-1:0] hq, input logic hw, input logic hso,
                     input string tag);
        step(rst, en, md, d, sin, 1'b1, hq, hw, hso, 1'b1, tag);
    endtask

    // Monitor: serial_out sampled before the edge, q and wrap just after it.
    initial begin
        logic [EW-1:0] e;
        string t;
        logic pso0, pso5;
        forever begin
            @(negedge clock);
            #1;
            pso0 = so0;
            pso5 = so5;
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                cmp(t, "q0", q0, e[19:12]);
                cmp(t, "wrap0", {7'd0, wr0}, {7'd0, e[11]});
                cmp(t, "q55", q5, e[9:2]);
                cmp(t, "wrap55", {7'd0, wr5}, {7'd0, e[1]});
                if (e[20]) begin
                    cmp(t, "serial_out0", {7'd0, pso0}, {7'd0, e[10]});
                    cmp(t, "serial_out55", {7'd0, pso5}, {7'd0, e[0]});
                end
            end
        end
    end

    logic [W-1:0] rol_exp [8];

    initial begin
        rol_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        m0 = 'x;
        m5 = 'x;

        step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "reset");

        h(0, 0, 3'b001, 8'hA5, 0, 8'h00, 0, 0, "load_gated1");
        h(0, 0, 3'b001, 8'hA5, 0, 8'h00, 0, 0, "load_gated2");
        h(0, 1, 3'b001, 8'hA5, 0, 8'hA5, 0, 0, "load_en");
        h(0, 0, 3'b001, 8'h3C, 0, 8'hA5, 0, 0, "load_hold");

        h(0, 1, 3'b001, 8'h81, 0, 8'h81, 0, 0, "shift_load");
        h(0, 1, 3'b010, 8'h00, 0, 8'h02, 0, 1, "shift_left");
        h(0, 1, 3'b011, 8'h00, 1, 8'h81, 0, 0, "shift_right");

        h(0, 1, 3'b001, 8'h01, 0, 8'h01, 0, 0, "rot_load");
        for (int i = 0; i < 8; i++) begin
            h(0, 1, 3'b100, 8'h00, 1, rol_exp[i], 0, (i == 7), "rot_left");
        end
        h(0, 1, 3'b101, 8'h00, 1, 8'h80, 0, 1, "rot_right");

        h(0, 1, 3'b001, 8'hFE, 0, 8'hFE, 0, 0, "cnt_load");
        h(0, 1, 3'b110, 8'h00, 0, 8'hFF, 0, 0, "cnt_up1");
        h(0, 1, 3'b110, 8'h00, 0, 8'h00, 1, 0, "cnt_up_wrap");
        h(0, 1, 3'b111, 8'h00, 0, 8'hFF, 1, 0, "cnt_down_wrap");
        h(0, 1, 3'b000, 8'h00, 0, 8'hFF, 0, 0, "wrap_one_cycle");
        h(0, 0, 3'b110, 8'h12, 1, 8'hFF, 0, 0, "gated_up_no_wrap");
        h(0, 0, 3'b010, 8'h00, 0, 8'hFF, 0, 1, "so_msb_gated");
        h(0, 0, 3'b011, 8'h00, 0, 8'hFF, 0, 1, "so_lsb_gated");

        h(0, 1, 3'b001, 8'h7E, 0, 8'h7E, 0, 0, "rst_load");
        h(0, 1, 3'b110, 8'h00, 0, 8'h7F, 0, 0, "rst_count");
        h(1, 1, 3'b110, 8'h00, 0, 8'h00, 0, 0, "rst_mid_count");
        h(0, 1, 3'b110, 8'h00, 0, 8'h01, 0, 0, "rst_resume");
        h(1, 1, 3'b010, 8'hFF, 1, 8'h00, 0, 0, "rst_mid_shift");
        h(0, 1, 3'b010, 8'h00, 1, 8'h01, 0, 0, "shift_after_rst");
        h(0, 1, 3'b111, 8'h00, 0, 8'h00, 0, 0, "down_to_zero");
        h(0, 1, 3'b111, 8'h00, 0, 8'hFF, 1, 0, "down_wrap2");

        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
